// File: rtl/sram_port_arbiter.sv
// Two-master arbiter for one SRAM port: grants one byte/half/word access per cycle,
// builds word address, byte enables and replicated write data, and returns aligned read data.
module sram_port_arbiter #(
    parameter int unsigned AW       = 12,
    parameter bit          ARB_MODE = 1'b1
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          M0_REQ,
    input  logic          M0_WE,
    input  logic [AW+1:0] M0_ADDR,
    input  logic [1:0]    M0_SIZE,
    input  logic [31:0]   M0_WDATA,
    input  logic          M1_REQ,
    input  logic          M1_WE,
    input  logic [AW+1:0] M1_ADDR,
    input  logic [1:0]    M1_SIZE,
    input  logic [31:0]   M1_WDATA,
    output logic          M0_GNT,
    output logic          M1_GNT,
    output logic          M0_RVALID,
    output logic          M1_RVALID,
    output logic [31:0]   M0_RDATA,
    output logic [31:0]   M1_RDATA,
    output logic          M0_ERR,
    output logic          M1_ERR,
    output logic          SRAM_CSN,
    output logic [AW-1:0] SRAM_ADDR,
    output logic          SRAM_WE,
    output logic [3:0]    SRAM_BE,
    output logic [31:0]   SRAM_DI,
    input  logic [31:0]   SRAM_DO
);

    localparam int unsigned BAW = AW + 2;

    logic           last_grant;   // 1 = M1 was granted most recently
    logic           rd_pending;
    logic           err_pending;
    logic           acc_master;
    logic [1:0]     rd_off;
    logic [1:0]     rd_size;
    logic [31:0]    m0_rdata_q;
    logic [31:0]    m1_rdata_q;

    logic           g0;
    logic           g1;
    logic           any_gnt;
    logic           sel_we;
    logic [BAW-1:0] sel_addr;
    logic [1:0]     sel_size;
    logic [31:0]    sel_wdata;
    logic           legal;
    logic           acc;
    logic [31:0]    rd_data;

    // Arbitration; grants are forced low while reset is asserted
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (RESETn) begin
            if (M0_REQ && M1_REQ) begin
                if (!ARB_MODE || last_grant) g0 = 1'b1;
                else                         g1 = 1'b1;
            end else begin
                g0 = M0_REQ;
                g1 = M1_REQ;
            end
        end
    end

    assign any_gnt   = g0 | g1;
    assign M0_GNT    = g0;
    assign M1_GNT    = g1;
    assign sel_we    = g1 ? M1_WE    : M0_WE;
    assign sel_addr  = g1 ? M1_ADDR  : M0_ADDR;
    assign sel_size  = g1 ? M1_SIZE  : M0_SIZE;
    assign sel_wdata = g1 ? M1_WDATA : M0_WDATA;

    always_comb begin
        legal = 1'b0;
        case (sel_size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~sel_addr[0];
            2'b10:   legal = (sel_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign acc = any_gnt & legal;

    // SRAM request decode; idle cycles drive everything to zero
    always_comb begin
        SRAM_CSN  = 1'b1;
        SRAM_ADDR = '0;
        SRAM_WE   = 1'b0;
        SRAM_BE   = 4'b0000;
        SRAM_DI   = 32'h0;
        if (acc) begin
            SRAM_CSN  = 1'b0;
            SRAM_ADDR = sel_addr[AW+1:2];
            SRAM_WE   = sel_we;
            case (sel_size)
                2'b00: begin
                    SRAM_BE = 4'b0001 << sel_addr[1:0];
                    SRAM_DI = {4{sel_wdata[7:0]}};
                end
                2'b01: begin
                    SRAM_BE = sel_addr[1] ? 4'b1100 : 4'b0011;
                    SRAM_DI = {2{sel_wdata[15:0]}};
                end
                default: begin
                    SRAM_BE = 4'b1111;
                    SRAM_DI = sel_wdata;
                end
            endcase
        end
    end

    // Lane extraction; stale lanes from the SRAM are masked off
    always_comb begin
        case (rd_size)
            2'b00:   rd_data = {24'h0, SRAM_DO[{rd_off, 3'b000} +: 8]};
            2'b01:   rd_data = {16'h0, SRAM_DO[{rd_off[1], 4'b0000} +: 16]};
            default: rd_data = SRAM_DO;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            last_grant  <= 1'b1;
            rd_pending  <= 1'b0;
            err_pending <= 1'b0;
            acc_master  <= 1'b0;
            rd_off      <= 2'b00;
            rd_size     <= 2'b00;
            m0_rdata_q  <= 32'h0;
            m1_rdata_q  <= 32'h0;
        end else begin
            rd_pending  <= acc & ~sel_we;
            err_pending <= any_gnt & ~legal;
            if (any_gnt) begin
                last_grant <= g1;
                acc_master <= g1;
                rd_off     <= sel_addr[1:0];
                rd_size    <= sel_size;
            end
            if (rd_pending && !acc_master) m0_rdata_q <= rd_data;
            if (rd_pending &&  acc_master) m1_rdata_q <= rd_data;
        end
    end

    // Returned data is visible in the RVALID cycle and then held
    assign M0_RVALID = rd_pending & ~acc_master;
    assign M1_RVALID = rd_pending &  acc_master;
    assign M0_ERR    = err_pending & ~acc_master;
    assign M1_ERR    = err_pending &  acc_master;
    assign M0_RDATA  = M0_RVALID ? rd_data : m0_rdata_q;
    assign M1_RDATA  = M1_RVALID ? rd_data : m1_rdata_q;

endmodule
